// File: rtl/nibble_demux.sv
// Nibble demultiplexer: steers lane-tagged nibbles into four lane registers and presents
// the assembled word on a valid/ready port. Optional partial-word timeout: NIBBLE_DEMUX_TIMEOUT_EN.
module nibble_demux #(
  parameter int NIB_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NIB_W-1:0]   in_data,
  input  logic [1:0]         in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*NIB_W-1:0] out_data,
  output logic [3:0]         lane_mask,
  output logic               dup_err,
  output logic               timeout_err
);

  // state   | meaning
  // COLLECT | accepting nibbles into lane registers, word not yet complete
  // FULL    | all four lanes written, word offered on the output port
  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [3:0][NIB_W-1:0]   lane_q, lane_d;
  logic [3:0]              mask_q, mask_d;
  logic                    dup_q, dup_d;
  logic                    accept;

  assign in_ready  = (state_q == COLLECT) & ~rst;
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid & in_ready;
  assign out_data  = lane_q;
  assign lane_mask = mask_q;
  assign dup_err   = dup_q;

`ifdef NIBBLE_DEMUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  assign timeout_err = to_q;
`else
  // Feature compiled out; the parameter is still referenced so both builds share one interface.
  assign timeout_err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    mask_d  = mask_q;
    dup_d   = 1'b0;
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      COLLECT: begin
        if (accept) begin
          lane_d[in_sel] = in_data;
          mask_d[in_sel] = 1'b1;
          dup_d          = mask_q[in_sel];
          if (mask_d == 4'b1111) begin
            state_d = FULL;
          end
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
        else if (mask_q != 4'b0000) begin
          if (cnt_q == CNT_LAST) begin
            lane_d = '0;
            mask_d = '0;
            cnt_d  = '0;
            to_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      FULL: begin
        if (out_ready) begin
          lane_d  = '0;
          mask_d  = '0;
          state_d = COLLECT;
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: begin
        state_d = COLLECT;
        lane_d  = '0;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      lane_q  <= '0;
      mask_q  <= '0;
      dup_q   <= 1'b0;
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      mask_q  <= mask_d;
      dup_q   <= dup_d;
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_demux.sv
// Scoreboard bench for nibble_demux: stimulus pushes expected words, a monitor pops them
// on each output handshake. Timeout scenario follows NIBBLE_DEMUX_TIMEOUT_EN.
module tb_nibble_demux;

  localparam int NIB_W = 4;
  localparam int TCYC  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NIB_W-1:0]  in_data = '0;
  logic [1:0]        in_sel = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4*NIB_W-1:0] out_data;
  logic [3:0]        lane_mask;
  logic              dup_err;
  logic              timeout_err;

  int errors = 0;
  int checks = 0;
  int consumed = 0;
  int dup_pulses = 0;
  logic [15:0] exp_q[$];

  nibble_demux #(.NIB_W(NIB_W), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .lane_mask(lane_mask), .dup_err(dup_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  // monitor: every output handshake must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && dup_err) dup_pulses++;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %h, required no word", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        consumed++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL word_data: got %h, required %h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [3:0] d);
    in_valid = 1'b1; in_sel = sel; in_data = d;
    tick();
    in_valid = 1'b0; in_sel = 'x; in_data = 'x;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_valid", 16'(out_valid), 16'd0);
    chk("consume_mask", 16'(lane_mask), 16'd0);
  endtask

  typedef struct { logic [1:0] sel; logic [3:0] d; logic [3:0] mask; } vec_t;

  initial begin
    vec_t v3 [4];
    int dup0, c0;
    v3[0] = '{2'd3, 4'hA, 4'b1000};
    v3[1] = '{2'd1, 4'hB, 4'b1010};
    v3[2] = '{2'd0, 4'hC, 4'b1011};
    v3[3] = '{2'd2, 4'hD, 4'b1111};

    // 1: reset values, reset mid-word
    #2;
    chk("rst_ready", 16'(in_ready), 16'd0);
    chk("rst_valid", 16'(out_valid), 16'd0);
    tick(); rst = 1'b0; #1;
    chk("rel_ready", 16'(in_ready), 16'd1);
    send(2'd0, 4'h5);
    send(2'd1, 4'h6);
    chk("pre_rst_mask", 16'(lane_mask), 16'h0003);
    rst = 1'b1; #1;
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_mask", 16'(lane_mask), 16'd0);
    chk("mid_rst_data", out_data, 16'h0000);
    chk("mid_rst_ready", 16'(in_ready), 16'd0);
    tick(); rst = 1'b0; #1;
    chk("rel2_ready", 16'(in_ready), 16'd1);

    // 2: in-order lanes
    exp_q.push_back(16'h4321);
    send(2'd0, 4'h1); send(2'd1, 4'h2); send(2'd2, 4'h3);
    chk("t2_valid_early", 16'(out_valid), 16'd0);
    send(2'd3, 4'h4);
    chk("t2_valid", 16'(out_valid), 16'd1);
    chk("t2_ready", 16'(in_ready), 16'd0);
    consume();
    chk("t2_ready_back", 16'(in_ready), 16'd1);

    // 3: out-of-order lanes
    exp_q.push_back(16'hADBC);
    foreach (v3[i]) begin
      send(v3[i].sel, v3[i].d);
      chk("t3_mask", 16'(lane_mask), 16'(v3[i].mask));
    end
    chk("t3_valid", 16'(out_valid), 16'd1);
    consume();

    // 4: duplicate lane
    dup0 = dup_pulses;
    send(2'd1, 4'h5);
    chk("t4_no_dup", 16'(dup_err), 16'd0);
    send(2'd1, 4'h7);
    chk("t4_dup", 16'(dup_err), 16'd1);
    chk("t4_mask", 16'(lane_mask), 16'h0002);
    tick();
    chk("t4_dup_clear", 16'(dup_err), 16'd0);
    exp_q.push_back(16'h3271);
    send(2'd0, 4'h1); send(2'd2, 4'h2); send(2'd3, 4'h3);
    tick();
    chk("t4_dup_count", 16'(dup_pulses - dup0), 16'd1);
    consume();

    // 5: backpressure while FULL
    exp_q.push_back(16'h1234);
    send(2'd0, 4'h4); send(2'd1, 4'h3); send(2'd2, 4'h2); send(2'd3, 4'h1);
    c0 = consumed;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i % 3 == 0) begin
        chk("t5_ready", 16'(in_ready), 16'd0);
        chk("t5_data", out_data, 16'h1234);
      end
    end
    chk("t5_mask", 16'(lane_mask), 16'h000F);
    in_valid = 1'b0;
    consume();
    tick(); tick();
    chk("t5_consumed", 16'(consumed - c0), 16'd1);

    // 6: partial word timeout
    send(2'd2, 4'h9);
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
    for (int i = 0; i < TCYC - 1; i++) tick();
    chk("t6_no_early", 16'(timeout_err), 16'd0);
    chk("t6_mask_pre", 16'(lane_mask), 16'h0004);
    tick();
    chk("t6_pulse", 16'(timeout_err), 16'd1);
    chk("t6_mask", 16'(lane_mask), 16'd0);
    tick();
    chk("t6_pulse_end", 16'(timeout_err), 16'd0);
`else
    for (int i = 0; i < 3 * TCYC; i++) begin
      tick();
      if (timeout_err) chk("t6_no_pulse", 16'(timeout_err), 16'd0);
    end
    chk("t6_mask_held", 16'(lane_mask), 16'h0004);
    chk("t6_timeout_low", 16'(timeout_err), 16'd0);
`endif

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
